// File: rtl/vga_rx_capture.sv
// Receive-side VGA capture: locks a local column/row counter to incoming sync
// leading edges, emits a per-pixel valid stream and per-frame lit-pixel counts.
module vga_rx_capture #(
  parameter int   H_DISP   = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_DISP   = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        rgb,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err,
  output logic [18:0] lit_count,
  output logic        lit_valid
);

  localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
  localparam logic [9:0] H_START    = 10'(H_DISP + H_FP);
  localparam logic [9:0] V_START    = 10'(V_DISP + V_FP);
  localparam logic [9:0] H_VIS      = 10'(H_DISP);
  localparam logic [9:0] V_VIS      = 10'(V_DISP);
  localparam logic [9:0] H_VIS_LAST = 10'(H_DISP - 1);
  localparam logic [9:0] V_VIS_LAST = 10'(V_DISP - 1);

  logic [9:0]  hcnt_reg, vcnt_reg;
  logic        hs_prev_reg, vs_prev_reg;
  logic        h_seen_reg, v_seen_reg;
  logic        h_lock_reg, v_lock_reg;
  logic [18:0] acc_reg;
  logic        armed_reg;

  logic        sample, hle, vle, h_wrap;
  logic [9:0]  h_pred, v_pred, hcnt_next, vcnt_next;
  logic        h_err, v_err;
  logic        h_lock_next, v_lock_next, lock_next;
  logic        vis, first_pix, last_pix, armed_eff, lit_fire;
  logic [18:0] acc_base, acc_sum, acc_next;
  logic        armed_next;

  always_comb begin
    sample    = enable & p_tick;
    hle       = (hsync == SYNC_POL) & (hs_prev_reg != SYNC_POL);
    vle       = (vsync == SYNC_POL) & (vs_prev_reg != SYNC_POL);

    h_pred    = (hcnt_reg == H_LAST) ? 10'd0 : hcnt_reg + 10'd1;
    // A sync edge overrides the wrap, so the row only advances on a true 799->0.
    h_wrap    = (hcnt_reg == H_LAST) & ~hle;
    if (h_wrap) v_pred = (vcnt_reg == V_LAST) ? 10'd0 : vcnt_reg + 10'd1;
    else        v_pred = vcnt_reg;

    hcnt_next = hle ? H_START : h_pred;
    vcnt_next = vle ? V_START : v_pred;

    h_err     = hle & h_seen_reg & (h_pred != H_START);
    v_err     = vle & v_seen_reg & (v_pred != V_START);

    h_lock_next = h_lock_reg;
    if (hle & h_seen_reg) h_lock_next = ~h_err;
    v_lock_next = v_lock_reg;
    if (vle & v_seen_reg) v_lock_next = ~v_err;
    if (h_err)            v_lock_next = 1'b0;
    lock_next = h_lock_next & v_lock_next;

    vis       = lock_next & (hcnt_next < H_VIS) & (vcnt_next < V_VIS);
    first_pix = vis & (hcnt_next == 10'd0) & (vcnt_next == 10'd0);
    last_pix  = vis & (hcnt_next == H_VIS_LAST) & (vcnt_next == V_VIS_LAST);

    // Counting only starts at a frame origin seen under lock, so a frame in
    // which lock was (re)gained part-way through is never reported.
    armed_eff = armed_reg | first_pix;
    acc_base  = first_pix ? 19'd0 : acc_reg;
    acc_sum   = acc_base + 19'(rgb);
    lit_fire  = last_pix & armed_eff;

    acc_next   = acc_reg;
    armed_next = armed_reg;
    if (!lock_next) begin
      acc_next   = 19'd0;
      armed_next = 1'b0;
    end else if (vis & armed_eff) begin
      acc_next   = last_pix ? 19'd0 : acc_sum;
      armed_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt_reg    <= '0;
      vcnt_reg    <= '0;
      hs_prev_reg <= ~SYNC_POL;
      vs_prev_reg <= ~SYNC_POL;
      h_seen_reg  <= 1'b0;
      v_seen_reg  <= 1'b0;
      h_lock_reg  <= 1'b0;
      v_lock_reg  <= 1'b0;
      acc_reg     <= '0;
      armed_reg   <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      lit_count   <= '0;
      lit_valid   <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
      lit_valid   <= 1'b0;
      if (sample) begin
        hcnt_reg    <= hcnt_next;
        vcnt_reg    <= vcnt_next;
        hs_prev_reg <= hsync;
        vs_prev_reg <= vsync;
        h_seen_reg  <= h_seen_reg | hle;
        v_seen_reg  <= v_seen_reg | vle;
        h_lock_reg  <= h_lock_next;
        v_lock_reg  <= v_lock_next;
        acc_reg     <= acc_next;
        armed_reg   <= armed_next;
        pix_valid   <= vis;
        pix_x       <= hcnt_next;
        pix_y       <= vcnt_next;
        pix_rgb     <= rgb;
        frame_start <= first_pix;
        locked      <= lock_next;
        sync_err    <= h_err | v_err;
        lit_valid   <= lit_fire;
        if (lit_fire) lit_count <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_vga_rx_capture.sv
// Scoreboard bench for vga_rx_capture on a reduced 16x9 raster (8x4 visible):
// stimulus pushes expected pixels, lit counts and sync errors; a monitor pops them.
module tb_vga_rx_capture;

  localparam int HD = 8, HF = 2, HS = 3, HB = 3;
  localparam int VD = 4, VF = 1, VS = 2, VB = 2;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int HST = HD + HF;
  localparam int VST = VD + VF;
  localparam logic POL = 1'b1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0, p_tick = 1'b0, hsync = 1'b0, vsync = 1'b0, rgb = 1'b0;
  logic        pix_valid, pix_rgb, frame_start, locked, sync_err, lit_valid;
  logic [9:0]  pix_x, pix_y;
  logic [18:0] lit_count;

  vga_rx_capture #(
    .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(POL)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .p_tick(p_tick),
    .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .locked(locked), .sync_err(sync_err),
    .lit_count(lit_count), .lit_valid(lit_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   x;
    int   y;
    logic r;
    logic fs;
  } pix_t;

  pix_t pix_q[$];
  int   lit_q[$];
  int   err_q[$];
  pix_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // 0: checkerboard (16 lit), 1: 3x2 block at (2,1) (6 lit), 2: all ones (32 lit)
  function automatic logic pat(input int p, input int x, input int y);
    case (p)
      0:       return logic'(((x + y) & 1) == 1);
      1:       return logic'(x >= 2 && x < 5 && y >= 1 && y < 3);
      default: return 1'b1;
    endcase
  endfunction

  function automatic void push_pix(input int x, input int y, input logic r);
    pix_q.push_back('{x, y, r, logic'(x == 0 && y == 0)});
  endfunction

  task automatic tick(input int x, input int y, input logic r, input logic en);
    @(posedge clk); #1;
    hsync  = (x >= HST && x < HST + HS) ? POL : ~POL;
    vsync  = (y >= VST && y < VST + VS) ? POL : ~POL;
    rgb    = r;
    enable = en;
    p_tick = 1'b1;
    @(posedge clk); #1;
    p_tick = 1'b0;
  endtask

  task automatic run_frame(input int p, input bit exp_on, input int exp_lit);
    for (int y = 0; y < VT; y++)
      for (int x = 0; x < HT; x++) begin
        if (exp_on && x < HD && y < VD) push_pix(x, y, pat(p, x, y));
        if (exp_on && x == HD - 1 && y == VD - 1 && exp_lit >= 0) lit_q.push_back(exp_lit);
        tick(x, y, pat(p, x, y), 1'b1);
      end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    forever begin
      @(negedge clk);
      if (pix_valid) begin
        if (pix_q.size() == 0) begin
          check("unexpected_pix_valid", int'(pix_x) * 1000 + int'(pix_y), -1);
        end else begin
          mon_e = pix_q.pop_front();
          check("pix_x", int'(pix_x), mon_e.x);
          check("pix_y", int'(pix_y), mon_e.y);
          check("pix_rgb", int'(pix_rgb), int'(mon_e.r));
          check("frame_start", int'(frame_start), int'(mon_e.fs));
        end
      end else if (frame_start) begin
        check("frame_start_without_valid", 1, 0);
      end
      if (lit_valid) begin
        $display("lit_valid lit_count=%0d", lit_count);
        if (lit_q.size() == 0) check("unexpected_lit_valid", int'(lit_count), -1);
        else check("lit_count", int'(lit_count), lit_q.pop_front());
      end
      if (sync_err) begin
        $display("sync_err at pix_x=%0d pix_y=%0d", pix_x, pix_y);
        if (err_q.size() == 0) check("unexpected_sync_err", int'(pix_x), -1);
        else void'(err_q.pop_front());
      end
    end
  end

  initial begin
    // Reset held with random inputs: everything stays at zero.
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      hsync  = 1'($urandom);
      vsync  = 1'($urandom);
      rgb    = 1'($urandom);
      p_tick = 1'($urandom);
      enable = 1'($urandom);
      @(negedge clk);
      check("reset_outputs_zero",
            int'(|{pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked,
                   sync_err, lit_count, lit_valid}), 0);
    end
    @(posedge clk); #1;
    p_tick = 1'b0; enable = 1'b1; hsync = ~POL; vsync = ~POL; rgb = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("locked_after_release", int'(locked), 0);

    // Clean lock: second hle in frame 0, second vle in frame 1.
    run_frame(0, 1'b0, -1);
    check("locked_after_frame0", int'(locked), 0);
    run_frame(0, 1'b0, -1);
    check("locked_after_frame1", int'(locked), 1);
    run_frame(0, 1'b1, 16);
    run_frame(1, 1'b1, 6);
    run_frame(2, 1'b1, 32);

    // Source jumps to the sync position at column 5 of row 2.
    begin
      bit gl = 1'b0;
      for (int y = 0; y < VT; y++)
        for (int x = 0; x < HT; x++) begin
          if (y == 2 && x == 5) begin
            x = HST;
            err_q.push_back(1);
            tick(x, y, pat(0, x, y), 1'b1);
            check("glitch_pix_x", int'(pix_x), HST);
            check("glitch_locked", int'(locked), 0);
            gl = 1'b1;
          end else begin
            if (!gl && x < HD && y < VD) push_pix(x, y, pat(0, x, y));
            tick(x, y, pat(0, x, y), 1'b1);
          end
        end
    end
    check("relocked_after_glitch", int'(locked), 1);
    run_frame(0, 1'b1, 16);

    // Enable low for 5 samples (row 1, cols 3..7) while the source keeps running.
    for (int y = 0; y < VT; y++)
      for (int x = 0; x < HT; x++) begin
        if ((y == 0 && x < HD) || (y == 1 && x < 3)) push_pix(x, y, pat(0, x, y));
        else if (y == 1 && (x == 8 || x == 9)) push_pix(x - 5, 1, pat(0, x, 1));
        if (y == 1 && x == HST) err_q.push_back(2);
        tick(x, y, pat(0, x, y), !(y == 1 && x >= 3 && x <= 7));
      end
    check("relocked_after_drop", int'(locked), 1);
    run_frame(1, 1'b1, 6);

    // Enable low with the source paused: no error, contiguous columns.
    for (int y = 0; y < VT; y++)
      for (int x = 0; x < HT; x++) begin
        if (x < HD && y < VD) push_pix(x, y, pat(0, x, y));
        if (x == HD - 1 && y == VD - 1) lit_q.push_back(16);
        tick(x, y, pat(0, x, y), 1'b1);
        if (y == 1 && x == 3)
          for (int k = 0; k < 5; k++) tick(HST, VST, ~pat(0, x, y), 1'b0);
      end
    check("locked_after_pause", int'(locked), 1);

    // Reset at (5,2) of an all-ones frame: no report, immediate clear, reacquire.
    for (int y = 0; y < VT; y++)
      for (int x = 0; x < HT; x++) begin
        if (y == 2 && x == 5) begin
          @(negedge clk); #1;
          reset = 1'b0;
          #1;
          check("midreset_locked", int'(locked), 0);
          check("midreset_lit_count", int'(lit_count), 0);
          check("midreset_pix_x", int'(pix_x), 0);
          check("midreset_pix_y", int'(pix_y), 0);
          check("midreset_pix_rgb", int'(pix_rgb), 0);
          check("midreset_pulses", int'(|{pix_valid, frame_start, sync_err, lit_valid}), 0);
          repeat (3) @(posedge clk);
          #1 reset = 1'b1;
        end
        if ((y < 2 || (y == 2 && x < 5)) && x < HD && y < VD) push_pix(x, y, 1'b1);
        tick(x, y, pat(2, x, y), 1'b1);
      end
    check("locked_after_reset_frame", int'(locked), 0);
    run_frame(2, 1'b0, -1);
    check("locked_reacquired", int'(locked), 1);
    run_frame(2, 1'b1, 32);

    repeat (4) @(posedge clk);
    check("pix_queue_left", pix_q.size(), 0);
    check("lit_queue_left", lit_q.size(), 0);
    check("err_queue_left", err_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
